// File: rtl/snake_pkg.sv
// Shared snake-game definitions: grid size, cell/direction codes, writer FSM states.
// Imported by the grid writer and the VGA read side so both agree on cell encoding.
package snake_pkg;

    localparam int GRID_N = 15;

    typedef enum logic [1:0] {
        CELL_WORLD = 2'b00,
        CELL_FOOD  = 2'b01,
        CELL_SNAKE = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    typedef enum logic [3:0] {
        ST_CLEAR,
        ST_INIT_HEAD,
        ST_FOOD_PICK,
        ST_FOOD_READ,
        ST_FOOD_CHECK,
        ST_IDLE,
        ST_MV_READ,
        ST_MV_CHECK,
        ST_MV_HEAD,
        ST_MV_TAIL,
        ST_DEAD
    } state_t;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } pos_t;

    // Up/down and left/right differ only in the top direction bit.
    function automatic dir_t dir_opposite(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/snake_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) for food placement; advances every cycle.
// Output is the register itself; no handshake, never stalls.
module snake_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    output logic [7:0] lfsr_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/snake_grid_writer.sv
// Write-side owner of the snake grid: clears the board, moves the snake, places food.
// One grid write per cycle, all outputs registered; step is dropped unless the FSM is IDLE.
module snake_grid_writer
    import snake_pkg::*;
#(
    parameter int         GRID_N    = snake_pkg::GRID_N,
    parameter int         MAX_LEN   = 32,
    parameter int         START_X   = 8,
    parameter int         START_Y   = 8,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic [1:0] dir,
    output logic       wr_en,
    output logic [3:0] wr_x,
    output logic [3:0] wr_y,
    output logic [1:0] wr_data,
    output logic [3:0] rd_x,
    output logic [3:0] rd_y,
    input  logic [1:0] rd_data,
    output logic       busy,
    output logic       game_over,
    output logic [5:0] length
);

    localparam int         PW        = $clog2(MAX_LEN);
    localparam logic [3:0] GRID_LAST = 4'(GRID_N);
    localparam logic [4:0] GRID_HI   = 5'(GRID_N);
    localparam logic [5:0] LEN_MAX   = 6'(MAX_LEN);
    localparam pos_t       START_POS = '{x: 4'(START_X), y: 4'(START_Y)};

    state_t        state_q;
    dir_t          heading_q;
    pos_t          head_q;
    pos_t          next_q;
    pos_t          tail_pos_q;
    logic          grow_q;
    logic [3:0]    clr_x_q;
    logic [3:0]    clr_y_q;
    logic [PW-1:0] head_ptr_q;
    logic [PW-1:0] tail_ptr_q;
    pos_t          body_q [MAX_LEN];

    logic          wr_en_q;
    logic [3:0]    wr_x_q;
    logic [3:0]    wr_y_q;
    cell_t         wr_data_q;
    logic [3:0]    rd_x_q;
    logic [3:0]    rd_y_q;
    logic          busy_q;
    logic          game_over_q;
    logic [5:0]    length_q;

    logic [7:0]    lfsr_w;
    dir_t          eff_dir_d;
    logic [4:0]    nx_d;
    logic [4:0]    ny_d;
    logic          off_grid_d;
    pos_t          next_d;
    logic          push_d;

    snake_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk_i (clk),
        .rst_ni(reset),
        .lfsr_o(lfsr_w)
    );

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_LEN - 1)) ? '0 : p + 1'b1;
    endfunction

    // Reversal requests keep the current heading; 5-bit math exposes the off-grid case.
    always_comb begin
        eff_dir_d = dir_t'(dir);
        if (eff_dir_d == dir_opposite(heading_q)) begin
            eff_dir_d = heading_q;
        end
        nx_d = {1'b0, head_q.x};
        ny_d = {1'b0, head_q.y};
        case (eff_dir_d)
            DIR_UP:    ny_d = ny_d - 5'd1;
            DIR_RIGHT: nx_d = nx_d + 5'd1;
            DIR_DOWN:  ny_d = ny_d + 5'd1;
            DIR_LEFT:  nx_d = nx_d - 5'd1;
        endcase
        off_grid_d = (nx_d == 5'd0) || (nx_d > GRID_HI) || (ny_d == 5'd0) || (ny_d > GRID_HI);
        next_d     = '{x: nx_d[3:0], y: ny_d[3:0]};
        push_d     = (state_q == ST_MV_CHECK) && (rd_data != CELL_SNAKE);
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_INIT_HEAD) begin
            body_q[0] <= START_POS;
        end else if (push_d) begin
            body_q[ptr_inc(head_ptr_q)] <= next_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_CLEAR;
            heading_q   <= DIR_RIGHT;
            head_q      <= '0;
            next_q      <= '0;
            tail_pos_q  <= '0;
            grow_q      <= 1'b0;
            clr_x_q     <= 4'd1;
            clr_y_q     <= 4'd1;
            head_ptr_q  <= '0;
            tail_ptr_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_x_q      <= '0;
            wr_y_q      <= '0;
            wr_data_q   <= CELL_WORLD;
            rd_x_q      <= '0;
            rd_y_q      <= '0;
            busy_q      <= 1'b1;
            game_over_q <= 1'b0;
            length_q    <= 6'd1;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                ST_CLEAR: begin
                    wr_en_q   <= 1'b1;
                    wr_x_q    <= clr_x_q;
                    wr_y_q    <= clr_y_q;
                    wr_data_q <= CELL_WORLD;
                    if (clr_x_q == GRID_LAST) begin
                        clr_x_q <= 4'd1;
                        if (clr_y_q == GRID_LAST) begin
                            clr_y_q <= 4'd1;
                            state_q <= ST_INIT_HEAD;
                        end else begin
                            clr_y_q <= clr_y_q + 4'd1;
                        end
                    end else begin
                        clr_x_q <= clr_x_q + 4'd1;
                    end
                end
                ST_INIT_HEAD: begin
                    wr_en_q    <= 1'b1;
                    wr_x_q     <= START_POS.x;
                    wr_y_q     <= START_POS.y;
                    wr_data_q  <= CELL_SNAKE;
                    head_q     <= START_POS;
                    head_ptr_q <= '0;
                    tail_ptr_q <= '0;
                    length_q   <= 6'd1;
                    state_q    <= ST_FOOD_PICK;
                end
                ST_FOOD_PICK: begin
                    if (lfsr_w[3:0] != 4'd0 && lfsr_w[7:4] != 4'd0) begin
                        rd_x_q  <= lfsr_w[3:0];
                        rd_y_q  <= lfsr_w[7:4];
                        state_q <= ST_FOOD_READ;
                    end
                end
                ST_FOOD_READ: begin
                    state_q <= ST_FOOD_CHECK;
                end
                ST_FOOD_CHECK: begin
                    if (rd_data == CELL_WORLD) begin
                        wr_en_q   <= 1'b1;
                        wr_x_q    <= rd_x_q;
                        wr_y_q    <= rd_y_q;
                        wr_data_q <= CELL_FOOD;
                        busy_q    <= 1'b0;
                        state_q   <= ST_IDLE;
                    end else begin
                        state_q <= ST_FOOD_PICK;
                    end
                end
                ST_IDLE: begin
                    if (step) begin
                        heading_q <= eff_dir_d;
                        if (off_grid_d) begin
                            game_over_q <= 1'b1;
                            state_q     <= ST_DEAD;
                        end else begin
                            next_q  <= next_d;
                            rd_x_q  <= next_d.x;
                            rd_y_q  <= next_d.y;
                            busy_q  <= 1'b1;
                            state_q <= ST_MV_READ;
                        end
                    end
                end
                ST_MV_READ: begin
                    state_q <= ST_MV_CHECK;
                end
                ST_MV_CHECK: begin
                    if (rd_data == CELL_SNAKE) begin
                        game_over_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_DEAD;
                    end else begin
                        grow_q     <= (rd_data == CELL_FOOD);
                        wr_en_q    <= 1'b1;
                        wr_x_q     <= next_q.x;
                        wr_y_q     <= next_q.y;
                        wr_data_q  <= CELL_SNAKE;
                        head_q     <= next_q;
                        head_ptr_q <= ptr_inc(head_ptr_q);
                        // Capture before the push can overwrite this slot when the buffer is full.
                        tail_pos_q <= body_q[tail_ptr_q];
                        state_q    <= ST_MV_HEAD;
                    end
                end
                ST_MV_HEAD: begin
                    if (grow_q && length_q != LEN_MAX) begin
                        length_q <= length_q + 6'd1;
                        state_q  <= ST_FOOD_PICK;
                    end else begin
                        wr_en_q    <= 1'b1;
                        wr_x_q     <= tail_pos_q.x;
                        wr_y_q     <= tail_pos_q.y;
                        wr_data_q  <= CELL_WORLD;
                        tail_ptr_q <= ptr_inc(tail_ptr_q);
                        state_q    <= ST_MV_TAIL;
                    end
                end
                ST_MV_TAIL: begin
                    if (grow_q) begin
                        state_q <= ST_FOOD_PICK;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_DEAD: begin
                    state_q <= ST_DEAD;
                end
                default: begin
                    state_q <= ST_DEAD;
                end
            endcase
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_x      = wr_x_q;
    assign wr_y      = wr_y_q;
    assign wr_data   = wr_data_q;
    assign rd_x      = rd_x_q;
    assign rd_y      = rd_y_q;
    assign busy      = busy_q;
    assign game_over = game_over_q;
    assign length    = length_q;

endmodule

// File: tb/tb_snake_grid_writer.sv
// Bench for snake_grid_writer: grid memory model behind the ports plus a body/food reference model.
module tb_snake_grid_writer;

    localparam int MAX_LEN = 32;

    typedef struct {int x; int y;} xy_t;
    typedef struct {int x; int y; int d; int prev;} wr_ent_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       step;
    logic [1:0] dir;
    logic       wr_en;
    logic [3:0] wr_x, wr_y, rd_x, rd_y;
    logic [1:0] wr_data;
    logic [1:0] rd_data = 2'b00;
    logic       busy, game_over;
    logic [5:0] length;
    logic       force_food;

    logic [1:0] mem [16][16];
    wr_ent_t    wlog[$];

    xy_t body_m[$];
    int  heading_m;
    bit  dead_m;
    bit  food_m [0:16][0:16];

    int n_checks = 0;
    int n_fail   = 0;

    snake_grid_writer dut (
        .clk      (clk),
        .reset    (rst_n),
        .step     (step),
        .dir      (dir),
        .wr_en    (wr_en),
        .wr_x     (wr_x),
        .wr_y     (wr_y),
        .wr_data  (wr_data),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .rd_data  (rd_data),
        .busy     (busy),
        .game_over(game_over),
        .length   (length)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_en) mem[wr_x][wr_y] <= wr_data;
        rd_data <= force_food ? 2'b01 : mem[rd_x][rd_y];
    end

    always @(negedge clk) begin
        if (rst_n && wr_en)
            wlog.push_back('{int'(wr_x), int'(wr_y), int'(wr_data), int'(mem[wr_x][wr_y])});
    end

    function automatic bit in_body(int x, int y);
        foreach (body_m[i]) if (body_m[i].x == x && body_m[i].y == y) return 1'b1;
        return 1'b0;
    endfunction

    function automatic xy_t next_of(int d);
        xy_t h;
        h = body_m[body_m.size() - 1];
        case (d)
            0: h.y = h.y - 1;
            1: h.x = h.x + 1;
            2: h.y = h.y + 1;
            default: h.x = h.x - 1;
        endcase
        return h;
    endfunction

    function automatic bit on_grid(xy_t p);
        return p.x >= 1 && p.x <= 15 && p.y >= 1 && p.y <= 15;
    endfunction

    // First direction (right, down, up, left order) that is not a reversal and lands on a free cell.
    function automatic int pick_safe();
        int order [4] = '{1, 2, 0, 3};
        xy_t p;
        foreach (order[i]) begin
            if (order[i] == (heading_m ^ 2)) continue;
            p = next_of(order[i]);
            if (on_grid(p) && !in_body(p.x, p.y) && !food_m[p.x][p.y]) return order[i];
        end
        return -1;
    endfunction

    task automatic do_boot();
        int cyc, errs;
        xy_t f;
        rst_n = 1'b0; step = 1'b0; force_food = 1'b0;
        repeat (3) @(negedge clk);
        wlog.delete();
        rst_n = 1'b1;
        cyc = 0;
        while (busy !== 1'b0 && cyc < 4000) begin @(negedge clk); cyc++; end
        @(negedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || wlog.size() != 227) begin
            n_fail++;
            $display("FAIL boot_done busy=%b writes=%0d, required busy=0 writes=227", busy, wlog.size());
        end
        body_m.delete(); body_m.push_back('{8, 8});
        heading_m = 1; dead_m = 1'b0;
        foreach (food_m[i, j]) food_m[i][j] = 1'b0;
        if (wlog.size() >= 227) begin
            errs = 0;
            for (int i = 0; i < 225; i++)
                if (wlog[i].x != (i % 15) + 1 || wlog[i].y != (i / 15) + 1 || wlog[i].d != 0) errs++;
            n_checks++;
            if (errs != 0) begin
                n_fail++;
                $display("FAIL boot_clear %0d of 225 writes out of row-major order or not 00, required 0", errs);
            end
            n_checks++;
            if (wlog[225].x != 8 || wlog[225].y != 8 || wlog[225].d != 2) begin
                n_fail++;
                $display("FAIL boot_head got (%0d,%0d)=%0d, required (8,8)=2", wlog[225].x, wlog[225].y, wlog[225].d);
            end
            f = '{wlog[226].x, wlog[226].y};
            n_checks++;
            if (wlog[226].d != 1 || !on_grid(f) || (f.x == 8 && f.y == 8)) begin
                n_fail++;
                $display("FAIL boot_food got (%0d,%0d)=%0d, required code 1 on grid and not (8,8)", f.x, f.y, wlog[226].d);
            end
            if (on_grid(f)) food_m[f.x][f.y] = 1'b1;
        end
        n_checks++;
        if (length !== 6'd1 || game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL boot_status length=%0d game_over=%b, required 1 and 0", length, game_over);
        end
    endtask

    task automatic do_move(input int d, input bit frc, input bit extra);
        int eff, cyc, nf;
        xy_t nh, tl, f;
        bit wall, self_hit, grow, at_max, fok;
        eff      = (d == (heading_m ^ 2)) ? heading_m : d;
        nh       = next_of(eff);
        wall     = !on_grid(nh);
        self_hit = !wall && in_body(nh.x, nh.y);
        grow     = !wall && !self_hit && (frc || food_m[nh.x][nh.y]);
        at_max   = (body_m.size() == MAX_LEN);
        tl       = body_m[0];
        wlog.delete();
        dir = 2'(d); step = 1'b1; force_food = frc;
        @(posedge clk); @(negedge clk);
        step = 1'b0;
        heading_m = eff;
        if (wall) begin
            force_food = 1'b0;
            dead_m = 1'b1;
            n_checks++;
            if (game_over !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL wall_death game_over=%b busy=%b wr_en=%b, required 1 0 0", game_over, busy, wr_en);
            end
            return;
        end
        n_checks++;
        if (int'(rd_x) != nh.x || int'(rd_y) != nh.y || busy !== 1'b1 || wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL mv_read rd=(%0d,%0d) busy=%b wr_en=%b, required (%0d,%0d) 1 0", rd_x, rd_y, busy, wr_en, nh.x, nh.y);
        end
        if (extra) step = 1'b1;
        @(negedge clk);
        step = 1'b0; force_food = 1'b0;
        n_checks++;
        if (wr_en !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mv_check wr_en=%b busy=%b, required 0 1", wr_en, busy);
        end
        @(negedge clk);
        if (self_hit) begin
            dead_m = 1'b1;
            n_checks++;
            if (game_over !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL self_death game_over=%b busy=%b wr_en=%b, required 1 0 0", game_over, busy, wr_en);
            end
            return;
        end
        n_checks++;
        if (wr_en !== 1'b1 || int'(wr_x) != nh.x || int'(wr_y) != nh.y || wr_data !== 2'b10) begin
            n_fail++;
            $display("FAIL mv_head wr_en=%b (%0d,%0d)=%0d, required 1 (%0d,%0d)=2", wr_en, wr_x, wr_y, wr_data, nh.x, nh.y);
        end
        body_m.push_back(nh);
        food_m[nh.x][nh.y] = 1'b0;
        @(negedge clk);
        if (!grow || at_max) begin
            void'(body_m.pop_front());
            n_checks++;
            if (wr_en !== 1'b1 || int'(wr_x) != tl.x || int'(wr_y) != tl.y || wr_data !== 2'b00) begin
                n_fail++;
                $display("FAIL mv_tail wr_en=%b (%0d,%0d)=%0d, required 1 (%0d,%0d)=0", wr_en, wr_x, wr_y, wr_data, tl.x, tl.y);
            end
        end else begin
            n_checks++;
            if (wr_en !== 1'b0) begin
                n_fail++;
                $display("FAIL grow_no_tail wr_en=%b, required 0", wr_en);
            end
        end
        if (!grow) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0 || int'(length) != body_m.size()) begin
                n_fail++;
                $display("FAIL mv_idle busy=%b length=%0d, required 0 %0d", busy, length, body_m.size());
            end
            if (extra) begin
                @(negedge clk);
                n_checks++;
                if (busy !== 1'b0 || wr_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL step_dropped busy=%b wr_en=%b, required 0 0", busy, wr_en);
                end
            end
            return;
        end
        cyc = 0;
        while (busy !== 1'b0 && cyc < 2000) begin @(negedge clk); cyc++; end
        @(negedge clk); #1;
        nf = 0; fok = 1'b0; f = '{0, 0};
        foreach (wlog[i]) if (wlog[i].d == 1) begin
            nf++;
            f = '{wlog[i].x, wlog[i].y};
            fok = on_grid(f) && wlog[i].prev == 0 && !in_body(f.x, f.y) && !food_m[f.x][f.y];
        end
        n_checks++;
        if (busy !== 1'b0 || nf != 1 || !fok) begin
            n_fail++;
            $display("FAIL grow_food busy=%b food_writes=%0d at (%0d,%0d) free=%b, required 0 1 1", busy, nf, f.x, f.y, fok);
        end
        if (on_grid(f)) food_m[f.x][f.y] = 1'b1;
        n_checks++;
        if (int'(length) != body_m.size()) begin
            n_fail++;
            $display("FAIL grow_len length=%0d, required %0d", length, body_m.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (wr_en !== 1'b0 || wr_x !== 4'd0 || wr_y !== 4'd0 || wr_data !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_wr wr_en=%b wr=(%0d,%0d)=%0d, required 0 (0,0)=0", wr_en, wr_x, wr_y, wr_data);
        end
        n_checks++;
        if (rd_x !== 4'd0 || rd_y !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_rd rd=(%0d,%0d), required (0,0)", rd_x, rd_y);
        end
        n_checks++;
        if (busy !== 1'b1 || game_over !== 1'b0 || length !== 6'd1) begin
            n_fail++;
            $display("FAIL rst_status busy=%b game_over=%b length=%0d, required 1 0 1", busy, game_over, length);
        end
        do_boot();
    endtask

    task automatic test_first_move();
        int d;
        d = pick_safe();
        if (d >= 0) do_move(d, 1'b0, 1'b0);
    endtask

    task automatic test_opposite();
        if (!dead_m) do_move(heading_m ^ 2, 1'b0, 1'b0);
    endtask

    task automatic test_force_grow();
        int d;
        d = pick_safe();
        if (!dead_m && d >= 0) do_move(d, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int d;
        d = pick_safe();
        if (!dead_m && d >= 0) do_move(d, 1'b0, 1'b1);
    endtask

    task automatic test_wall();
        for (int k = 0; k < 20 && !dead_m; k++) do_move(1, 1'b0, 1'b0);
    endtask

    task automatic test_dead();
        int wr_seen;
        if (!dead_m) return;
        wr_seen = 0;
        for (int i = 0; i < 3; i++) begin
            dir = 2'($urandom_range(0, 3));
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            repeat (4) begin @(negedge clk); if (wr_en !== 1'b0) wr_seen++; end
        end
        n_checks++;
        if (wr_seen != 0 || game_over !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL dead_hold writes=%0d game_over=%b busy=%b, required 0 1 0", wr_seen, game_over, busy);
        end
    endtask

    task automatic test_reset_mid_move();
        do_boot();
        dir = 2'd1; step = 1'b1;
        @(posedge clk); @(negedge clk);
        step = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (wr_en !== 1'b1 || wr_x !== 4'd9 || wr_y !== 4'd8) begin
            n_fail++;
            $display("FAIL rst_mid_pre wr_en=%b (%0d,%0d), required 1 (9,8)", wr_en, wr_x, wr_y);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (wr_en !== 1'b0 || busy !== 1'b1 || wr_x !== 4'd0 || length !== 6'd1) begin
            n_fail++;
            $display("FAIL rst_mid_async wr_en=%b busy=%b wr_x=%0d length=%0d, required 0 1 0 1", wr_en, busy, wr_x, length);
        end
        do_boot();
    endtask

    task automatic test_random();
        for (int k = 0; k < 40 && !dead_m; k++)
            do_move(int'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic test_board();
        int errs, exp_c;
        @(negedge clk);
        errs = 0;
        for (int x = 1; x <= 15; x++)
            for (int y = 1; y <= 15; y++) begin
                exp_c = in_body(x, y) ? 2 : (food_m[x][y] ? 1 : 0);
                if (int'(mem[x][y]) != exp_c) errs++;
            end
        n_checks++;
        if (errs != 0) begin
            n_fail++;
            $display("FAIL board %0d cells differ from body/food model, required 0", errs);
        end
    endtask

    initial begin
        rst_n = 1'b0; step = 1'b0; dir = 2'b01; force_food = 1'b0;
        foreach (mem[i, j]) mem[i][j] = 2'b11;
        repeat (2) @(negedge clk);
        test_reset();
        test_first_move();
        test_opposite();
        test_force_grow();
        test_back_to_back();
        test_wall();
        test_dead();
        test_reset_mid_move();
        test_random();
        test_board();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
